// File: rtl/riscv_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: one radix-2 step per cycle,
// early completion for divide-by-zero and signed overflow, flushable at any time.
module riscv_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? ('0 - v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? ('0 - v) : v;
  endfunction

  logic              a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign is_div   = op[2];
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign a_mag    = cneg(a, sa);
  assign b_mag    = cneg(b, sb);
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  // Remainder takes the dividend's sign; quotient and product take the XOR.
  assign neg_in   = (is_div && op[1]) ? sa : (sa ^ sb);

  // acc holds {partial product hi, multiplier} or {partial remainder, quotient}
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{acc_q[0]}} & opb_q)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_sh - {1'b0, opb_q};
    div_next  = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod      = cneg2(step_next, neg_q);
    case (op_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = cneg(step_next[XLEN-1:0], neg_q);
      default:                final_res = cneg(step_next[2*XLEN-1:XLEN], neg_q);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          neg_d = neg_in;
          opb_d = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = CW'(XLEN);
          if (div_zero) begin
            result_d = op[1] ? a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : a;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
    cnt_q <= cnt_d;
    acc_q <= acc_d;
    opb_q <= opb_d;
    op_q  <= op_d;
    neg_q <= neg_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE) && !flush && !rst;
  assign result    = result_q;

endmodule

// File: doc/riscv_mdu.md
# riscv_mdu

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the single-cycle ALU and accepts one operation at a time through a valid/ready handshake. Multiplies and divides complete in a fixed number of cycles; the divide-by-zero and signed-overflow corner cases complete early. A flush input lets the pipeline kill an in-flight operation.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  abort current operation, discard result
- out_valid  out  1  one-cycle pulse, result valid
- result  out  XLEN  result; holds last value until next out_valid

## Operation
- States: IDLE, CALC, DONE.
- Accept when in_valid && in_ready && !flush; op, a, b latched; signed ops store operand magnitudes plus result-sign flags.
- IDLE -> DONE directly (fast path) when: op is DIV/DIVU/REM/REMU with b == 0; or op is DIV/REM with a == most-negative and b == all-ones.
- IDLE -> CALC otherwise; iteration counter loaded with XLEN.
- CALC: one radix-2 step per cycle (shift-add for multiply into 2*XLEN accumulator; restoring shift-subtract for divide). After the XLEN-th step, sign fixup (two's-complement negate where needed) and result select are applied and the result is registered; -> DONE.
- DONE: out_valid = 1 for exactly one cycle; -> IDLE.
- Result selection: MUL low XLEN of product; MULH/MULHSU/MULHU high XLEN of signed×signed, signed×unsigned, unsigned×unsigned product. DIV/DIVU quotient rounded toward zero; REM/REMU remainder with sign of dividend.
- Divide by zero: quotient all ones (DIV and DIVU), remainder = a.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
- flush: from any state -> IDLE next cycle; out_valid forced 0 that cycle; result register unchanged. flush with in_valid in IDLE: request not accepted.
- rst: identical effect to flush plus result cleared.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, state IDLE.
- Accept at edge N. Normal path: out_valid high in cycle N+XLEN+1 (33 cycles for XLEN=32). Fast path: out_valid high in cycle N+1.
- in_ready low from cycle after acceptance until state returns to IDLE; next accept earliest one cycle after out_valid (throughput XLEN+2 normal, 2 fast).
- No acceptance during DONE; in_valid asserted while in_ready low is ignored, requester must hold.
- Operands a/b/op may change after acceptance without effect.
- result updates on the same edge out_valid rises and stays stable until the next out_valid.
- Flush or rst mid-CALC: counter and accumulator discarded, no out_valid ever issued for that operation.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, single-cycle pulse; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH a=b=0xFFFFFFFF -> 0x00000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REMU -> 5, each with out_valid one cycle after accept; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, REM -> 0, fast path.
- Back-to-back: in_valid held high with two queued ops -> second accepted exactly one cycle after first out_valid, in_ready low throughout CALC/DONE.
- Flush at 10th CALC cycle of a DIVU -> no out_valid, result keeps prior value, in_ready = 1 next cycle, a fresh MUL 3×4 then returns 12.
- rst asserted mid-CALC -> next cycle in_ready = 1, out_valid = 0, result = 0; simultaneous flush and in_valid in IDLE -> request not accepted.
